// File: rtl/jt89_wr_seq.sv
`default_nettype none
// ============================================================================
// jt89_wr_seq : command FIFO + byte serialiser driving the JT89 write port.
// Optional macro JT89_WR_SKIP_EN: skip tone data bytes equal to the shadow.
// Revision: 1.0
// ============================================================================
module jt89_wr_seq #(
   parameter int DEPTH   = 4,
   parameter int WR_LOW  = 2,
   parameter int WR_HIGH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic [2:0] i_cmd_reg,
   input  logic [9:0] i_cmd_data,
   output logic [7:0] o_psg_din,
   output logic       o_psg_wr_n,
   output logic       o_busy
);

   localparam int c_pw   = $clog2(DEPTH);
   localparam int c_cw   = $clog2((WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH) + 1;
   localparam logic [c_cw-1:0] c_low_last  = c_cw'(WR_LOW - 1);
   localparam logic [c_cw-1:0] c_high_last = c_cw'(WR_HIGH - 1);
   localparam logic [c_pw:0]   c_depth     = (c_pw+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH} state_t;

   state_t            r_state, w_state_nxt;
   logic [12:0]       r_mem [DEPTH];
   logic [c_pw-1:0]   r_wr_ptr, r_rd_ptr;
   logic [c_pw:0]     r_count;
   logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
   logic [7:0]        r_din;
   logic              r_wr_n, r_busy;
   logic              r_pend;
   logic [5:0]        r_pend_byte;
   logic              w_full, w_empty, w_push, w_pop;
   logic              w_load_latch, w_load_data;
   logic [12:0]       w_head;
   logic [2:0]        w_head_reg;
   logic [9:0]        w_head_data;
   logic [7:0]        w_latch;
   logic              w_tone, w_skip;

   assign w_full      = (r_count == c_depth);
   assign w_empty     = (r_count == '0);
   assign w_push      = i_cmd_valid && !w_full;
   assign o_cmd_ready = !w_full;

   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_reg  = w_head[12:10];
   assign w_head_data = w_head[9:0];
   assign w_tone      = !w_head_reg[0] && (w_head_reg != 3'd6);

   always_comb begin
      w_latch = {1'b1, w_head_reg, w_head_data[3:0]};
      if (w_head_reg == 3'd6) w_latch = {5'b11100, w_head_data[2:0]};
   end

`ifdef JT89_WR_SKIP_EN
   logic [5:0] r_shadow [4];
   logic [3:0] r_shadow_v;
   logic [1:0] r_pend_ch;

   assign w_skip = w_tone && r_shadow_v[w_head_reg[2:1]] &&
                   (r_shadow[w_head_reg[2:1]] == w_head_data[9:4]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow_v <= '0;
         r_pend_ch  <= '0;
         for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
      end else begin
         if (w_pop) r_pend_ch <= w_head_reg[2:1];
         if (w_load_data) begin
            r_shadow_v[r_pend_ch] <= 1'b1;
            r_shadow[r_pend_ch]   <= r_pend_byte;
         end
      end
   end
`else
   assign w_skip = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {i_cmd_reg, i_cmd_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   // Pending data byte takes priority so a tone's two bytes stay adjacent.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_pop        = 1'b0;
      w_load_latch = 1'b0;
      w_load_data  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_load_latch = 1'b1;
               w_state_nxt  = S_SETUP;
            end
         end
         S_SETUP: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_LOW;
         end
         S_LOW: begin
            if (r_cnt == c_low_last) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_HIGH;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_HIGH: begin
            if (r_cnt == c_high_last) begin
               if (r_pend) begin
                  w_load_data = 1'b1;
                  w_state_nxt = S_SETUP;
               end else if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_load_latch = 1'b1;
                  w_state_nxt  = S_SETUP;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_din       <= 8'h00;
         r_wr_n      <= 1'b1;
         r_busy      <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_byte <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wr_n  <= (w_state_nxt != S_LOW);
         r_busy  <= !w_empty || (r_state != S_IDLE);
         if (w_load_latch) begin
            r_din       <= w_latch;
            r_pend      <= w_tone && !w_skip;
            r_pend_byte <= w_head_data[9:4];
         end else if (w_load_data) begin
            r_din  <= {2'b00, r_pend_byte};
            r_pend <= 1'b0;
         end
      end
   end

   assign o_psg_din  = r_din;
   assign o_psg_wr_n = r_wr_n;
   assign o_busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_jt89_wr_seq.sv
`default_nettype none
// ============================================================================
// tb_jt89_wr_seq : timeline model of the byte stream plus directed vectors.
// Revision: 1.0
// ============================================================================
module tb_jt89_wr_seq;

   localparam int DEPTH = 4;
   localparam int WL    = 2;
   localparam int WH    = 2;
   localparam int P     = 1 + WL + WH;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_cmd_valid;
   logic       o_cmd_ready;
   logic [2:0] i_cmd_reg;
   logic [9:0] i_cmd_data;
   logic [7:0] o_psg_din;
   logic       o_psg_wr_n;
   logic       o_busy;

   jt89_wr_seq #(.DEPTH(DEPTH), .WR_LOW(WL), .WR_HIGH(WH)) dut (
      .clk(clk), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_reg(i_cmd_reg), .i_cmd_data(i_cmd_data), .o_psg_din(o_psg_din),
      .o_psg_wr_n(o_psg_wr_n), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Timeline model: every byte owns a window [start, start+P-1]; a command's
   // first byte starts at max(accept+2, end of previous byte).
   int         acc_q[$];
   int         pop_q[$];
   int         bs_q[$];
   logic [7:0] bv_q[$];
   int         last_end = 0;
   logic [5:0] sh [4];
   logic [3:0] sh_v = '0;

   function automatic int cnt_at(int c);
      int n = 0;
      foreach (acc_q[i]) if (acc_q[i] < c) n++;
      foreach (pop_q[i]) if (pop_q[i] < c) n--;
      return n;
   endfunction

   function automatic bit inwin(int x);
      foreach (bs_q[i]) if (bs_q[i] <= x && x <= bs_q[i] + P - 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit low_at(int c);
      foreach (bs_q[i]) if (bs_q[i] + 1 <= c && c <= bs_q[i] + WL) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [7:0] din_at(int c);
      logic [7:0] v = 8'h00;
      foreach (bs_q[i]) if (bs_q[i] <= c) v = bv_q[i];
      return v;
   endfunction

   function automatic void model_accept(int t, logic [2:0] r, logic [9:0] d);
      logic [7:0] lb;
      bit         tone, two;
      int         s;
      lb   = (r == 3'd6) ? {5'b11100, d[2:0]} : {1'b1, r, d[3:0]};
      tone = (r == 3'd0) || (r == 3'd2) || (r == 3'd4);
      two  = tone;
`ifdef JT89_WR_SKIP_EN
      if (tone && sh_v[r[2:1]] && sh[r[2:1]] == d[9:4]) two = 1'b0;
      if (two) begin
         sh_v[r[2:1]] = 1'b1;
         sh[r[2:1]]   = d[9:4];
      end
`endif
      s = (t + 2 > last_end) ? t + 2 : last_end;
      acc_q.push_back(t);
      pop_q.push_back(s - 1);
      bs_q.push_back(s);
      bv_q.push_back(lb);
      last_end = s + P;
      if (two) begin
         bs_q.push_back(s + P);
         bv_q.push_back({2'b00, d[9:4]});
         last_end = s + 2 * P;
      end
   endfunction

   logic [7:0] ob_b[$];
   int         ob_c[$];
   bit         last_acc = 1'b0;
   bit         seen_nr  = 1'b0;
   logic       prev_wr_n = 1'b1;
   logic       prev_busy = 1'b0;
   int         bf_cyc = -1;

   always @(negedge clk) begin
      if (!rst_n) begin
         acc_q.delete(); pop_q.delete(); bs_q.delete(); bv_q.delete();
         last_end = 0;
         sh_v     = '0;
         last_acc = 1'b0;
         chk("rst_wr_n", o_psg_wr_n, 1'b1);
         chk("rst_din", o_psg_din, 8'h00);
         chk("rst_busy", o_busy, 1'b0);
         chk("rst_ready", o_cmd_ready, 1'b1);
      end else begin
         bit er;
         er = (cnt_at(cyc) < DEPTH);
         chk("ready", o_cmd_ready, er);
         chk("wr_n", o_psg_wr_n, !low_at(cyc));
         chk("din", o_psg_din, din_at(cyc));
         chk("busy", o_busy, (cnt_at(cyc - 1) != 0) || inwin(cyc - 1));
         if (i_cmd_valid && !o_cmd_ready) seen_nr = 1'b1;
         last_acc = i_cmd_valid && er;
         if (last_acc) model_accept(cyc, i_cmd_reg, i_cmd_data);
         if (prev_wr_n && !o_psg_wr_n) begin
            ob_b.push_back(o_psg_din);
            ob_c.push_back(cyc);
         end
         if (prev_busy && !o_busy) bf_cyc = cyc;
      end
      prev_wr_n = o_psg_wr_n;
      prev_busy = o_busy;
   end

   task automatic send(input logic [2:0] r, input logic [9:0] d);
      int g = 0;
      i_cmd_reg   = r;
      i_cmd_data  = d;
      i_cmd_valid = 1'b1;
      do begin
         @(posedge clk);
         g++;
      end while (!last_acc && g < 60);
      if (!last_acc) chk("send_timeout", 1'b0, 1'b1);
      #1 i_cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] loop_tone0();
      logic [9:0] tn [3];
      logic [2:0] lr = 3'd0;
      foreach (tn[i]) tn[i] = '0;
      foreach (ob_b[i]) begin
         if (ob_b[i][7]) begin
            lr = ob_b[i][6:4];
            if (!lr[0] && lr != 3'd6) tn[lr[2:1]][3:0] = ob_b[i][3:0];
         end else if (!lr[0] && lr != 3'd6) begin
            tn[lr[2:1]][9:4] = ob_b[i][5:0];
         end
      end
      return tn[0];
   endfunction

   task automatic clear_obs();
      ob_b.delete();
      ob_c.delete();
   endtask

   initial begin
      int g;
      rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_reg = '0; i_cmd_data = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      send(3'd0, 10'h2A5);
      idle(20);
      chk("t1_nbytes", ob_b.size(), 2);
      if (ob_b.size() == 2) begin
         chk("t1_latch", ob_b[0], 8'h85);
         chk("t1_data", ob_b[1], 8'h2A);
         chk("t1_period", ob_c[1] - ob_c[0], P);
      end
      chk("t1_loopback", loop_tone0(), 10'h2A5);
      clear_obs();

      send(3'd5, 10'h3A7);
      idle(15);
      chk("t2_nbytes", ob_b.size(), 1);
      if (ob_b.size() == 1) begin
         chk("t2_byte", ob_b[0], 8'hD7);
         chk("t2_busy_fall", bf_cyc, ob_c[0] + 5);
      end
      clear_obs();

      send(3'd6, 10'h00F);
      idle(15);
      chk("t3_nbytes", ob_b.size(), 1);
      if (ob_b.size() == 1) chk("t3_byte", ob_b[0], 8'hE7);
      clear_obs();

      seen_nr = 1'b0;
      send(3'd1, 10'h001);
      send(3'd3, 10'h002);
      send(3'd5, 10'h003);
      send(3'd7, 10'h004);
      send(3'd1, 10'h005);
      send(3'd3, 10'h006);
      idle(45);
      chk("t4_saw_full", seen_nr, 1'b1);
      chk("t4_nbytes", ob_b.size(), 6);
      if (ob_b.size() == 6) begin
         chk("t4_b0", ob_b[0], 8'h91);
         chk("t4_b1", ob_b[1], 8'hB2);
         chk("t4_b2", ob_b[2], 8'hD3);
         chk("t4_b3", ob_b[3], 8'hF4);
         chk("t4_b4", ob_b[4], 8'h95);
         chk("t4_b5", ob_b[5], 8'hB6);
      end
      clear_obs();

      send(3'd2, 10'h100);
      send(3'd2, 10'h100);
      idle(30);
`ifdef JT89_WR_SKIP_EN
      chk("t5_nbytes", ob_b.size(), 3);
`else
      chk("t5_nbytes", ob_b.size(), 4);
      if (ob_b.size() == 4) chk("t5_b3", ob_b[3], 8'h10);
`endif
      if (ob_b.size() >= 3) begin
         chk("t5_b0", ob_b[0], 8'hA0);
         chk("t5_b1", ob_b[1], 8'h10);
         chk("t5_b2", ob_b[2], 8'hA0);
      end
      clear_obs();

      send(3'd0, 10'h3FF);
      send(3'd3, 10'h005);
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (o_psg_wr_n && g < 20);
      if (o_psg_wr_n) chk("t6_low_timeout", 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_wr_n_async", o_psg_wr_n, 1'b1);
      chk("t6_busy_async", o_busy, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_obs();
      idle(30);
      chk("t6_no_bytes", ob_b.size(), 0);
      chk("t6_busy_end", o_busy, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
